axi_gran_ar_merger: RTL and testbench
=====================================

Name: axi_gran_ar_merger

Overview:
- Read-side counterpart to the granular burst splitter. It sits on the slave side of a fragmenting link and coalesces contiguous same-ID INCR AR sub-bursts back into longer downstream bursts, up to a runtime length limit.
- It regenerates the original per-fragment `r.last` upstream.
- AW/W/B pass through combinationally and untouched.

Parameters:
- IdWidth, 0, AXI ID width.
- AddrWidth, 0, AXI address width.
- FragDepth, 8, fragment-length FIFO entries; this bounds outstanding upstream ARs.
- axi_req_t, logic, AXI request struct.
- axi_resp_t, logic, AXI response struct.
- axi_ar_chan_t, logic, AR channel struct.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset
- merge_limit_i  in  8  maximum merged len (axi_pkg::len_t); 0 disables merging
- timeout_i  in  8  idle cycles a held AR waits for a merge partner
- slv_req_i  in  axi_req_t  upstream request
- slv_resp_o  out  axi_resp_t  upstream response
- mst_req_o  out  axi_req_t  downstream request
- mst_resp_i  in  axi_resp_t  downstream response

Interface: one clock; reset is synchronous and active-high.

Behaviour:
- Reset (rst_i high at a clk_i edge) gives:
  - state IDLE, FIFO empty, beat counter 0, wait counter 0, cur_id 0;
  - mst_req_o.ar_valid=0, slv_resp_o.ar_ready=0.
  - r_valid follows mst_resp_i combinationally.
  - Reset mid-HOLD discards the held AR without emitting it.
- AR FSM states:
  - IDLE: ar_ready=1 iff FIFO not full AND (FIFO empty OR ar.id==cur_id). On handshake: latch ar into acc, push ar.len into FIFO, cur_id<=ar.id. Go to HOLD if the AR is eligible, else to EMIT.
  - Eligible: merge_limit_i!=0, burst==INCR, cache modifiable, atop==0, ar.len<merge_limit_i.
  - HOLD: wait counter starts at 0 on entry. An incoming AR is mergeable iff all of the following hold:
    - same id, size, cache, prot, qos, region, lock and user as acc;
    - ar.addr == acc.addr + ((acc.len+1)<<size);
    - merged range stays in the same 4 KiB page;
    - acc.len+ar.len+1 <= merge_limit_i;
    - FIFO not full.
  - HOLD on a mergeable AR: ar_ready=1, acc.len += ar.len+1 (9-bit compute, result fits 8 bits by the limit check), push ar.len, wait counter <= 0.
  - HOLD, otherwise: ar_ready=0. Go to EMIT if ar_valid (not mergeable), OR wait counter==timeout_i, OR acc.len==merge_limit_i. Else the wait counter increments (saturating at 255).
  - EMIT: mst ar_valid=1 with acc, stable until ar_ready. On handshake go to IDLE. slv ar_ready=0 in EMIT.
- The AR path is registered: minimum latency is 1 cycle for ineligible ARs and timeout_i+2 cycles for a lone eligible AR.
- merge_limit_i and timeout_i are sampled every cycle. Lowering merge_limit_i during HOLD forces EMIT on the next evaluation.
- Only one ID is outstanding at a time. A different ID stalls until all fragments of cur_id are drained (FIFO empty, state IDLE).
- R path:
  - r_valid and r_ready pass through combinationally; all R fields are forwarded except last.
  - Upstream last = (beat_cnt == FIFO head len).
  - On R handshake: if last, pop and set beat_cnt<=0, else beat_cnt++.
  - Simultaneous push and pop is allowed; FIFO full is judged before the pop.
- Assertions:
  - r_valid with empty FIFO → $fatal.
  - Downstream r.last must coincide with upstream last of a fragment.
  - mst ar.len <= max(merge_limit_i, accepted ar.len).

Decomposition:
- axi_gran_pkg:
  - merge_state_e {IDLE, HOLD, EMIT};
  - frag_len_t = axi_pkg::len_t;
  - function ar_mergeable(acc, ar, limit);
  - localparam PageBytes=4096.
- Sub-module axi_gran_ar_frag_fifo: synchronous-reset FIFO of frag_len_t, depth FragDepth, with full/empty/push/pop/head ports. It is kept separate so it can be verified standalone.

Test Plan:
- merge_limit=7, timeout=4, four back-to-back ARs (id 3, INCR, size 3, len 1, addr 0x1000/0x1010/0x1020/0x1030) → one mst AR addr 0x1000 len 7. Eight downstream R beats → upstream last on beats 2,4,6,8; FIFO empty afterwards.
- ARs 0x1000 len1 then 0x2000 len1 → two mst ARs, each len 1, with no merge.
- size 3: AR 0x1FF0 len1 then 0x2000 len1 → 4 KiB crossing, two separate mst ARs.
- timeout=4, single eligible AR, no follow-up → mst ar_valid rises exactly 6 cycles after the upstream handshake.
- id 3 outstanding, then AR id 5 presented → ar_ready low until the final R of id 3 is accepted upstream, then id 5 is accepted next cycle. Also merge_limit=0 → every AR passes through with len unchanged.
- Reset asserted one cycle during HOLD → no mst AR emitted, ar_valid=0, a subsequent AR is handled fresh with beat counter 0.

Source files
------------

// File: rtl/axi_gran_pkg.sv
// Shared types and helpers for the granular AR merger: AXI channel structs,
// FSM state encoding and the merge-eligibility check.
package axi_gran_pkg;

    localparam int unsigned IdW       = 4;
    localparam int unsigned AddrW     = 32;
    localparam int unsigned DataW     = 64;
    localparam int unsigned UserW     = 1;
    localparam int unsigned PageBytes = 4096;
    localparam int unsigned PageShift = $clog2(PageBytes);

    localparam logic [1:0] BurstIncr = 2'b01;

    typedef logic [7:0] len_t;
    typedef len_t       frag_len_t;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        EMIT
    } merge_state_e;

    typedef struct packed {
        logic [IdW-1:0]   id;
        logic [AddrW-1:0] addr;
        len_t             len;
        logic [2:0]       size;
        logic [1:0]       burst;
        logic             lock;
        logic [3:0]       cache;
        logic [2:0]       prot;
        logic [3:0]       qos;
        logic [3:0]       region;
        logic [5:0]       atop;
        logic [UserW-1:0] user;
    } aw_chan_t;

    typedef struct packed {
        logic [DataW-1:0]   data;
        logic [DataW/8-1:0] strb;
        logic               last;
        logic [UserW-1:0]   user;
    } w_chan_t;

    typedef struct packed {
        logic [IdW-1:0]   id;
        logic [1:0]       resp;
        logic [UserW-1:0] user;
    } b_chan_t;

    typedef struct packed {
        logic [IdW-1:0]   id;
        logic [AddrW-1:0] addr;
        len_t             len;
        logic [2:0]       size;
        logic [1:0]       burst;
        logic             lock;
        logic [3:0]       cache;
        logic [2:0]       prot;
        logic [3:0]       qos;
        logic [3:0]       region;
        logic [UserW-1:0] user;
    } ar_chan_t;

    typedef struct packed {
        logic [IdW-1:0]   id;
        logic [DataW-1:0] data;
        logic [1:0]       resp;
        logic             last;
        logic [UserW-1:0] user;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } resp_t;

    // True when ar directly continues acc with identical attributes, stays in
    // acc's 4 KiB page and the combined length fits within limit. AR carries no
    // atomic operation, so there is no atop term here.
    function automatic logic ar_mergeable(ar_chan_t acc, ar_chan_t ar, len_t limit);
        logic [AddrW-1:0] next_addr;
        logic [AddrW-1:0] last_addr;
        logic [8:0]       sum_len;
        logic             same_attr;
        next_addr = acc.addr + ((AddrW'(acc.len) + AddrW'(1)) << acc.size);
        last_addr = ar.addr + ((AddrW'(ar.len) + AddrW'(1)) << ar.size) - AddrW'(1);
        sum_len   = {1'b0, acc.len} + {1'b0, ar.len} + 9'd1;
        same_attr = (ar.id == acc.id) && (ar.size == acc.size) && (ar.cache == acc.cache) &&
                    (ar.prot == acc.prot) && (ar.qos == acc.qos) &&
                    (ar.region == acc.region) && (ar.lock == acc.lock) &&
                    (ar.user == acc.user);
        return same_attr && (ar.addr == next_addr) &&
               ((acc.addr >> PageShift) == (last_addr >> PageShift)) &&
               (sum_len <= {1'b0, limit});
    endfunction

endpackage

// File: rtl/axi_gran_ar_frag_fifo.sv
// FIFO of upstream fragment lengths; the head is the fragment whose R beats
// are currently being returned.
module axi_gran_ar_frag_fifo
    import axi_gran_pkg::*;
#(
    parameter int unsigned Depth = 8
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  frag_len_t push_len,
    input  logic      pop,
    output frag_len_t head_len,
    output logic      full,
    output logic      empty
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    frag_len_t       mem_q [Depth];
    logic [PtrW-1:0] wptr_q, rptr_q;
    logic [CntW-1:0] cnt_q;
    logic            do_push, do_pop;

    // Full is judged on the current count, so a push is refused even if a pop
    // happens in the same cycle.
    assign full     = (cnt_q == CntW'(Depth));
    assign empty    = (cnt_q == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign head_len = mem_q[rptr_q];

    // Storage array; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= push_len;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= (wptr_q == PtrW'(Depth - 1)) ? '0 : wptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rptr_q <= (rptr_q == PtrW'(Depth - 1)) ? '0 : rptr_q + PtrW'(1);
            end
            cnt_q <= cnt_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

endmodule

// File: rtl/axi_gran_ar_merger.sv
// Coalesces contiguous same-ID INCR AR fragments into longer downstream
// bursts and rebuilds each fragment's r.last on the way back. AW/W/B pass
// straight through.
module axi_gran_ar_merger
    import axi_gran_pkg::*;
#(
    parameter int unsigned IdWidth   = IdW,
    parameter int unsigned AddrWidth = AddrW,
    parameter int unsigned FragDepth = 8,
    parameter type axi_req_t     = req_t,
    parameter type axi_resp_t    = resp_t,
    parameter type axi_ar_chan_t = ar_chan_t
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  len_t       merge_limit_i,
    input  logic [7:0] timeout_i,
    input  axi_req_t   slv_req_i,
    output axi_resp_t  slv_resp_o,
    output axi_req_t   mst_req_o,
    input  axi_resp_t  mst_resp_i
);

    // The merge helper works on the package channel layout.
    if (IdWidth != IdW || AddrWidth != AddrW) begin : gen_width_check
        $error("axi_gran_ar_merger: IdWidth/AddrWidth must match axi_gran_pkg");
    end

    merge_state_e     state_q, state_d;
    axi_ar_chan_t     acc_q, acc_d;
    logic [IdWidth-1:0] cur_id_q, cur_id_d;
    logic [7:0]       wait_q, wait_d;
    len_t             beat_q, beat_d;
    logic             merged_q, merged_d;

    logic       fifo_push, fifo_pop, fifo_full, fifo_empty;
    frag_len_t  head_len;
    logic       ar_ready, ar_valid_out;
    logic       eligible, mergeable;
    logic [8:0] merged_len;
    logic       r_fire, up_last;

    axi_gran_ar_frag_fifo #(
        .Depth (FragDepth)
    ) u_frag_fifo (
        .clk      (clk_i),
        .rst      (rst_i),
        .push     (fifo_push),
        .push_len (slv_req_i.ar.len),
        .pop      (fifo_pop),
        .head_len (head_len),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign eligible = (merge_limit_i != '0) && (slv_req_i.ar.burst == BurstIncr) &&
                      slv_req_i.ar.cache[1] && (slv_req_i.ar.len < merge_limit_i);
    assign mergeable  = ar_mergeable(acc_q, slv_req_i.ar, merge_limit_i) && !fifo_full;
    assign merged_len = {1'b0, acc_q.len} + {1'b0, slv_req_i.ar.len} + 9'd1;

    // AR FSM: accept, hold for merge partners, emit the accumulated burst.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cur_id_d     = cur_id_q;
        wait_d       = wait_q;
        merged_d     = merged_q;
        fifo_push    = 1'b0;
        ar_ready     = 1'b0;
        ar_valid_out = 1'b0;
        unique case (state_q)
            IDLE: begin
                ar_ready = !fifo_full && (fifo_empty || (slv_req_i.ar.id == cur_id_q));
                if (slv_req_i.ar_valid && ar_ready) begin
                    acc_d     = slv_req_i.ar;
                    fifo_push = 1'b1;
                    cur_id_d  = slv_req_i.ar.id;
                    wait_d    = '0;
                    merged_d  = 1'b0;
                    state_d   = eligible ? HOLD : EMIT;
                end
            end
            HOLD: begin
                if (slv_req_i.ar_valid && mergeable) begin
                    ar_ready  = 1'b1;
                    acc_d.len = merged_len[7:0];
                    fifo_push = 1'b1;
                    wait_d    = '0;
                    merged_d  = 1'b1;
                end else if (slv_req_i.ar_valid || (wait_q == timeout_i) ||
                             (acc_q.len >= merge_limit_i)) begin
                    // >= so that a limit lowered below the held length still flushes.
                    state_d = EMIT;
                end else if (wait_q != 8'hFF) begin
                    wait_d = wait_q + 8'd1;
                end
            end
            EMIT: begin
                ar_valid_out = 1'b1;
                if (mst_resp_i.ar_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (rst_i) begin
            ar_ready     = 1'b0;
            fifo_push    = 1'b0;
            ar_valid_out = 1'b0;
        end
    end

    assign r_fire   = mst_resp_i.r_valid && slv_req_i.r_ready;
    assign up_last  = (beat_q == head_len);
    assign fifo_pop = r_fire && up_last && !fifo_empty;

    // Beat counter within the current upstream fragment.
    always_comb begin
        beat_d = beat_q;
        if (r_fire) begin
            beat_d = up_last ? '0 : beat_q + len_t'(1);
        end
    end

    // State registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            cur_id_q <= '0;
            wait_q   <= '0;
            beat_q   <= '0;
            merged_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cur_id_q <= cur_id_d;
            wait_q   <= wait_d;
            beat_q   <= beat_d;
            merged_q <= merged_d;
        end
    end

    // Channel muxing: everything passes through except AR and r.last.
    always_comb begin
        mst_req_o             = slv_req_i;
        mst_req_o.ar          = acc_q;
        mst_req_o.ar_valid    = ar_valid_out;
        slv_resp_o            = mst_resp_i;
        slv_resp_o.ar_ready   = ar_ready;
        slv_resp_o.r.last     = up_last;
    end

    a_r_has_frag: assert property (@(posedge clk_i) disable iff (rst_i)
        mst_resp_i.r_valid |-> !fifo_empty)
        else $fatal(1, "R beat returned with no outstanding fragment");

    a_last_aligned: assert property (@(posedge clk_i) disable iff (rst_i)
        (r_fire && mst_resp_i.r.last) |-> up_last)
        else $error("downstream r.last not on a fragment boundary");

    a_len_bound: assert property (@(posedge clk_i) disable iff (rst_i)
        (ar_valid_out && merged_q) |-> (acc_q.len <= merge_limit_i))
        else $error("merged AR exceeds merge limit");

endmodule

// File: tb/tb_axi_gran_ar_merger.sv
// Directed bench with a scoreboard: expected downstream ARs and upstream
// r.last values are queued by the stimulus and checked by a monitor.
module tb_axi_gran_ar_merger;
    import axi_gran_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    len_t       merge_limit;
    logic [7:0] timeout;
    req_t       slv_req, mst_req;
    resp_t      slv_resp, mst_resp;

    always #5 clk = ~clk;

    axi_gran_ar_merger #(
        .IdWidth   (IdW),
        .AddrWidth (AddrW),
        .FragDepth (8)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .merge_limit_i (merge_limit),
        .timeout_i     (timeout),
        .slv_req_i     (slv_req),
        .slv_resp_o    (slv_resp),
        .mst_req_o     (mst_req),
        .mst_resp_i    (mst_resp)
    );

    typedef struct packed {
        logic [IdW-1:0]   id;
        logic [AddrW-1:0] addr;
        len_t             len;
    } exp_ar_t;

    exp_ar_t exp_ar_q[$];
    bit      exp_last_q[$];
    int      checks = 0;
    int      passes = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: sample DUT outputs on the falling edge.
    exp_ar_t e;
    bit      el;
    always @(negedge clk) begin
        if (!rst && mst_req.ar_valid && mst_resp.ar_ready) begin
            if (exp_ar_q.size() == 0) chk("mst_ar_unexpected", 1, 0);
            else begin
                e = exp_ar_q.pop_front();
                chk("mst_ar_id", mst_req.ar.id, e.id);
                chk("mst_ar_addr", mst_req.ar.addr, e.addr);
                chk("mst_ar_len", mst_req.ar.len, e.len);
            end
        end
        if (!rst && slv_resp.r_valid && slv_req.r_ready) begin
            if (exp_last_q.size() == 0) chk("r_unexpected", 1, 0);
            else begin
                el = exp_last_q.pop_front();
                chk("slv_r_last", slv_resp.r.last, el);
            end
        end
    end

    // All drive tasks enter and leave at posedge + 1.
    task automatic send_ar(input logic [IdW-1:0] id, input logic [AddrW-1:0] addr,
                           input len_t len);
        int n;
        slv_req.ar       = '0;
        slv_req.ar.id    = id;
        slv_req.ar.addr  = addr;
        slv_req.ar.len   = len;
        slv_req.ar.size  = 3'd3;
        slv_req.ar.burst = BurstIncr;
        slv_req.ar.cache = 4'b0011;
        slv_req.ar_valid = 1'b1;
        @(negedge clk);
        n = 0;
        while (!slv_resp.ar_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("ar_accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        slv_req.ar_valid = 1'b0;
    endtask

    task automatic exp_ar(input logic [IdW-1:0] id, input logic [AddrW-1:0] addr,
                          input len_t len);
        exp_ar_t x;
        x.id = id;
        x.addr = addr;
        x.len = len;
        exp_ar_q.push_back(x);
    endtask

    task automatic push_frag(input int len);
        for (int i = 0; i <= len; i++) exp_last_q.push_back(i == len);
    endtask

    task automatic wait_ars_done();
        int n;
        n = 0;
        while (exp_ar_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("ar_drain_left", exp_ar_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic send_r(input int n, input bit dn_last);
        for (int i = 0; i < n; i++) begin
            mst_resp.r_valid = 1'b1;
            mst_resp.r.last  = dn_last && (i == n - 1);
            mst_resp.r.data  = 64'(i);
            @(posedge clk);
            #1;
        end
        mst_resp.r_valid = 1'b0;
        mst_resp.r.last  = 1'b0;
    endtask

    task automatic latency_after_hs(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mst_req.ar_valid && n < 30);
    endtask

    int lat;
    int cnt;

    initial begin
        slv_req           = '0;
        slv_req.r_ready   = 1'b1;
        mst_resp          = '0;
        mst_resp.ar_ready = 1'b1;
        merge_limit       = 8'd7;
        timeout           = 8'd4;

        // Reset state; r_valid follows downstream even in reset.
        mst_resp.r_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_r_valid_follow", slv_resp.r_valid, 1);
        chk("rst_ar_ready", slv_resp.ar_ready, 0);
        chk("rst_mst_ar_valid", mst_req.ar_valid, 0);
        mst_resp.r_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ar_ready", slv_resp.ar_ready, 1);
        chk("idle_mst_ar_valid", mst_req.ar_valid, 0);
        @(posedge clk);
        #1;

        // Four contiguous fragments merge into one len-7 burst.
        exp_ar(4'd3, 32'h1000, 8'd7);
        send_ar(4'd3, 32'h1000, 8'd1);
        send_ar(4'd3, 32'h1010, 8'd1);
        send_ar(4'd3, 32'h1020, 8'd1);
        send_ar(4'd3, 32'h1030, 8'd1);
        wait_ars_done();
        for (int i = 0; i < 4; i++) push_frag(1);
        send_r(8, 1'b1);

        // Non-contiguous: no merge.
        exp_ar(4'd3, 32'h1000, 8'd1);
        exp_ar(4'd3, 32'h2000, 8'd1);
        send_ar(4'd3, 32'h1000, 8'd1);
        send_ar(4'd3, 32'h2000, 8'd1);
        wait_ars_done();
        push_frag(1);
        send_r(2, 1'b1);
        push_frag(1);
        send_r(2, 1'b1);

        // Contiguous but crossing a 4 KiB page: no merge.
        exp_ar(4'd3, 32'h1FF0, 8'd1);
        exp_ar(4'd3, 32'h2000, 8'd1);
        send_ar(4'd3, 32'h1FF0, 8'd1);
        send_ar(4'd3, 32'h2000, 8'd1);
        wait_ars_done();
        push_frag(1);
        send_r(2, 1'b1);
        push_frag(1);
        send_r(2, 1'b1);

        // Lone eligible AR emits after timeout + 2 cycles.
        exp_ar(4'd3, 32'h8000, 8'd1);
        send_ar(4'd3, 32'h8000, 8'd1);
        latency_after_hs(lat);
        chk("lone_ar_latency", lat, 6);
        wait_ars_done();
        push_frag(1);
        send_r(2, 1'b1);

        // Merging disabled: pass-through with 1-cycle latency.
        merge_limit = 8'd0;
        exp_ar(4'd3, 32'h3000, 8'd2);
        send_ar(4'd3, 32'h3000, 8'd2);
        latency_after_hs(lat);
        chk("bypass_latency", lat, 1);
        wait_ars_done();

        // Different ID stalls until id 3 fully drains upstream.
        exp_ar(4'd5, 32'h6000, 8'd0);
        slv_req.ar       = '0;
        slv_req.ar.id    = 4'd5;
        slv_req.ar.addr  = 32'h6000;
        slv_req.ar.size  = 3'd3;
        slv_req.ar.burst = BurstIncr;
        slv_req.ar.cache = 4'b0011;
        slv_req.ar_valid = 1'b1;
        @(negedge clk);
        chk("stall_ready_before_r", slv_resp.ar_ready, 0);
        @(posedge clk);
        #1;
        push_frag(2);
        send_r(2, 1'b0);
        @(negedge clk);
        chk("stall_ready_mid_r", slv_resp.ar_ready, 0);
        @(posedge clk);
        #1;
        send_r(1, 1'b1);
        @(negedge clk);
        chk("stall_release_ready", slv_resp.ar_ready, 1);
        @(posedge clk);
        #1;
        slv_req.ar_valid = 1'b0;
        wait_ars_done();
        push_frag(0);
        send_r(1, 1'b1);

        // Merging disabled, back-to-back contiguous: both pass unchanged.
        exp_ar(4'd3, 32'h7000, 8'd1);
        exp_ar(4'd3, 32'h7010, 8'd1);
        send_ar(4'd3, 32'h7000, 8'd1);
        send_ar(4'd3, 32'h7010, 8'd1);
        wait_ars_done();
        push_frag(1);
        send_r(2, 1'b1);
        push_frag(1);
        send_r(2, 1'b1);

        // Reset during HOLD drops the held AR.
        merge_limit = 8'd7;
        timeout     = 8'd10;
        send_ar(4'd3, 32'h4000, 8'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (mst_req.ar_valid) cnt++;
        end
        chk("no_ar_after_reset", cnt, 0);
        @(posedge clk);
        #1;
        timeout = 8'd2;
        exp_ar(4'd6, 32'h5000, 8'd1);
        send_ar(4'd6, 32'h5000, 8'd1);
        wait_ars_done();
        push_frag(1);
        send_r(2, 1'b1);

        repeat (3) @(posedge clk);
        chk("exp_ar_left", exp_ar_q.size(), 0);
        chk("exp_r_left", exp_last_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
